hwpe_mdc_loop_ctrl: RTL
=======================

# hwpe_mdc_loop_ctrl

Parametrised nested-loop address sequencer for the MAC/MDC HWPE control path. It replaces the fixed two-loop microcode engine with N_LOOPS hardware counters. Each iteration it emits a per-stream byte offset for N_STREAMS streamer channels, computed incrementally from per-loop, per-stream strides. It sits between the main control FSM (start/done) and the streamer address generators (valid/ready offset stream).

## Interface
Parameters:
- N_LOOPS, 3, number of nested loops; loop 0 is innermost.
- N_STREAMS, 4, number of streamer channels receiving offsets.
- CNT_WIDTH, 16, width of each loop counter and bound.
- ADDR_WIDTH, 32, width of strides and offsets.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_ni  in  1  synchronous, active-low reset.
- clear_i  in  1  synchronous soft clear; same effect as reset.
- start_i  in  1  job start pulse; sampled only in IDLE.
- bound_i  in  N_LOOPS*CNT_WIDTH  per-loop iteration count minus one.
- stride_i  in  N_LOOPS*N_STREAMS*ADDR_WIDTH  per-loop, per-stream offset increment, two's complement.
- valid_o  out  1  offset tuple valid.
- ready_i  in  1  consumer accepts the tuple.
- offset_o  out  N_STREAMS*ADDR_WIDTH  current per-stream offset.
- idx_o  out  N_LOOPS*CNT_WIDTH  current loop indices.
- last_o  out  N_LOOPS  loop l is at its bound.
- busy_o  out  1  state is not IDLE.
- done_o  out  1  one-cycle end-of-job pulse.
- perf_cycles_o  out  32  cycles spent in RUN.
- perf_stalls_o  out  32  RUN cycles with valid_o=1 and ready_i=0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE + start_i: latch bound_i and stride_i into internal registers, zero all indices and accumulators, then go to RUN. Inputs are not sampled again until the next job.
- RUN: valid_o=1. A transfer happens when valid_o and ready_i are both high.
- On a transfer, j is the lowest loop with idx[j] != bound[j]:
  - idx[j] increments, and idx[k] clears to 0 for every k<j.
  - acc[j][s] += stride[j][s], and acc[k][s] takes the new acc[j][s] for every k<j.
  - acc[l][s] is the sum over k>=l of idx[k]*stride[k][s], so offset_o[s]=acc[0][s].
- If every loop is at its bound when a transfer happens, that was the final tuple: go to DONE and leave the counters unchanged.
- DONE: done_o=1 for one cycle, then IDLE.
- While valid_o=1 and ready_i=0, offset_o, idx_o and last_o hold stable.
- start_i in RUN or DONE is ignored.
- Total tuples per job = product over l of (bound[l]+1). A bound of 0 means that loop runs once.
- Arithmetic: accumulators wrap modulo 2^ADDR_WIDTH. Negative strides are legal.
- last_o[l] = (idx[l]==bound[l]) while in RUN; 0 otherwise.
- clear_i or !rst_ni, in any state, including mid-job: next state IDLE; all counters, accumulators and latched configuration go to 0; no done_o pulse.

## Timing
- Reset value of every output: valid_o, busy_o and done_o are 0; offset_o, idx_o, last_o and both perf counters are 0.
- start_i sampled high at edge t: busy_o=1 and valid_o=1 from t+1, with idx=0 and offset=0.
- Each transfer updates outputs at the next edge, so full throughput is one tuple per cycle.
- Final transfer at edge t: valid_o=0 and done_o=1 during t+1; busy_o=0 from t+2.
- Zero-wait job length: tuples+2 cycles from start to IDLE.
- The update path is one adder per (loop, stream) plus a priority select, with no further pipelining.

## Configuration
- Macro MDC_LOOP_CTRL_PERF_EN.
- Defined:
  - perf_cycles_o counts RUN cycles; perf_stalls_o counts RUN cycles with ready_i=0.
  - Both counters clear on start_i acceptance, reset and clear_i; they saturate at 2^32-1 and hold after DONE.
- Undefined: both outputs are tied to 0 and no counter registers are built.

## Test plan
- Basic two-loop job: N_LOOPS=2 with bound={1,2} (loop 0 bound 1, loop 1 bound 2), stride[0][0]=4, stride[1][0]=64, ready_i always 1 -> 6 tuples with offset_o[0]=0,4,64,68,128,132; done_o in cycle 8 after start.
- Backpressure: same job with ready_i=0 for 3 cycles at the third tuple -> offset_o[0] holds 64 for 4 cycles; with perf enabled, perf_stalls_o=3 and perf_cycles_o=9.
- Single-tuple job: all bounds 0 -> exactly one valid cycle with all outputs 0, last_o all 1, done_o the next cycle.
- Negative stride and wrap: stride[0][1]=0xFFFFFFFC, bound[0]=2 -> offset_o[1]=0, 0xFFFFFFFC, 0xFFFFFFF8.
- Clear mid-job: assert clear_i at the 2nd tuple of the basic job -> valid_o=0 and busy_o=0 next cycle with no done_o; a new start_i reproduces the full 6-tuple sequence.
- Start ignored and config latched: pulse start_i and change bound_i while in RUN -> sequence unchanged and only one done_o pulse.

Source files
------------

// File: rtl/hwpe_mdc_loop_ctrl_if.sv
// Offset stream from the loop sequencer to the streamer address generators.
// The master drives one offset/index tuple per valid cycle; the slave returns ready.
interface hwpe_mdc_loop_ctrl_if #(
    parameter int unsigned N_LOOPS    = 3,
    parameter int unsigned N_STREAMS  = 4,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH = 32
) ();
    logic                            valid;
    logic                            ready;
    logic [N_STREAMS*ADDR_WIDTH-1:0] offset;
    logic [N_LOOPS*CNT_WIDTH-1:0]    idx;
    logic [N_LOOPS-1:0]              last;

    modport master (output valid, offset, idx, last, input ready);
    modport slave  (input valid, offset, idx, last, output ready);
endinterface

// File: rtl/hwpe_mdc_loop_ctrl.sv
// Nested-loop address sequencer: N_LOOPS counters emitting incremental per-stream offsets.
// Optional perf counters are built only when MDC_LOOP_CTRL_PERF_EN is defined.
module hwpe_mdc_loop_ctrl #(
    parameter int unsigned N_LOOPS    = 3,
    parameter int unsigned N_STREAMS  = 4,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    clear_i,
    input  logic                                    start_i,
    input  logic [N_LOOPS*CNT_WIDTH-1:0]            bound_i,
    input  logic [N_LOOPS*N_STREAMS*ADDR_WIDTH-1:0] stride_i,
    hwpe_mdc_loop_ctrl_if.master                    stream_if,
    output logic                                    busy_o,
    output logic                                    done_o,
    output logic [31:0]                             perf_cycles_o,
    output logic [31:0]                             perf_stalls_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e r_state;
    state_e w_state_nxt;
    logic   w_start;
    logic   w_xfer;
    logic   w_step;

    logic        [CNT_WIDTH-1:0]  r_bound   [N_LOOPS];
    logic        [CNT_WIDTH-1:0]  r_idx     [N_LOOPS];
    logic signed [ADDR_WIDTH-1:0] r_stride  [N_LOOPS][N_STREAMS];
    logic signed [ADDR_WIDTH-1:0] r_acc     [N_LOOPS][N_STREAMS];
    logic signed [ADDR_WIDTH-1:0] w_sum     [N_LOOPS][N_STREAMS];
    logic signed [ADDR_WIDTH-1:0] w_sel_sum [N_STREAMS];

    logic [N_LOOPS-1:0] w_at_bound;
    logic [N_LOOPS-1:0] w_le;
    logic [N_LOOPS-1:0] w_hit;
    logic               w_all_last;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) r_state <= S_IDLE;
        else                    r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_xfer      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_xfer = stream_if.ready;
                if (w_xfer && w_all_last) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_step = w_xfer & ~w_all_last;

    // w_le marks loops at or below the lowest non-saturated loop j; w_hit marks j itself.
    always_comb begin
        w_at_bound = '0;
        w_le       = '0;
        w_hit      = '0;
        w_all_last = 1'b1;
        for (int l = 0; l < N_LOOPS; l++) begin
            w_at_bound[l] = (r_idx[l] == r_bound[l]);
            w_le[l]       = w_all_last;
            w_hit[l]      = w_all_last & ~w_at_bound[l];
            w_all_last    = w_all_last & w_at_bound[l];
        end
    end

    always_comb begin
        for (int s = 0; s < N_STREAMS; s++) begin
            w_sel_sum[s] = '0;
            for (int l = 0; l < N_LOOPS; l++) begin
                w_sum[l][s] = r_acc[l][s] + r_stride[l][s];
                if (w_hit[l]) w_sel_sum[s] = w_sum[l][s];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            for (int l = 0; l < N_LOOPS; l++) begin
                r_bound[l] <= '0;
                r_idx[l]   <= '0;
                for (int s = 0; s < N_STREAMS; s++) begin
                    r_stride[l][s] <= '0;
                    r_acc[l][s]    <= '0;
                end
            end
        end else if (w_start) begin
            for (int l = 0; l < N_LOOPS; l++) begin
                r_bound[l] <= bound_i[l*CNT_WIDTH +: CNT_WIDTH];
                r_idx[l]   <= '0;
                for (int s = 0; s < N_STREAMS; s++) begin
                    r_stride[l][s] <= $signed(stride_i[(l*N_STREAMS+s)*ADDR_WIDTH +: ADDR_WIDTH]);
                    r_acc[l][s]    <= '0;
                end
            end
        end else if (w_step) begin
            // Inner loops restart from the new outer accumulator, so offset stays a running sum.
            for (int l = 0; l < N_LOOPS; l++) begin
                if (w_le[l]) begin
                    r_idx[l] <= w_hit[l] ? r_idx[l] + CNT_WIDTH'(1) : '0;
                    for (int s = 0; s < N_STREAMS; s++) r_acc[l][s] <= w_sel_sum[s];
                end
            end
        end
    end

    always_comb begin
        stream_if.valid  = (r_state == S_RUN);
        stream_if.idx    = '0;
        stream_if.last   = '0;
        stream_if.offset = '0;
        for (int l = 0; l < N_LOOPS; l++) begin
            stream_if.idx[l*CNT_WIDTH +: CNT_WIDTH] = r_idx[l];
            stream_if.last[l] = (r_state == S_RUN) & w_at_bound[l];
        end
        for (int s = 0; s < N_STREAMS; s++)
            stream_if.offset[s*ADDR_WIDTH +: ADDR_WIDTH] = r_acc[0][s];
    end

    assign busy_o = (r_state != S_IDLE);
    assign done_o = (r_state == S_DONE);

`ifdef MDC_LOOP_CTRL_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_stalls;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i || w_start) begin
            r_perf_cycles <= '0;
            r_perf_stalls <= '0;
        end else if (r_state == S_RUN) begin
            r_perf_cycles <= sat_inc(r_perf_cycles);
            if (!stream_if.ready) r_perf_stalls <= sat_inc(r_perf_stalls);
        end
    end

    assign perf_cycles_o = r_perf_cycles;
    assign perf_stalls_o = r_perf_stalls;
`else
    assign perf_cycles_o = '0;
    assign perf_stalls_o = '0;
`endif

endmodule
